// File: rtl/axi_rd_arbiter.sv
// Two-master arbiter for a single AXI read-only slave port (AR + R channels).
// Optional macro ARB_RR_EN: round-robin tie break; undefined gives fixed priority to M0.
module axi_rd_arbiter #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic              ACLK,
    input  logic              ARESET,
    // master 0
    input  logic [ID_W-1:0]   M0_ARID,
    input  logic [ADDR_W-1:0] M0_ARADDR,
    input  logic [LEN_W-1:0]  M0_ARLEN,
    input  logic              M0_ARVALID,
    output logic              M0_ARREADY,
    output logic [ID_W-1:0]   M0_RID,
    output logic [DATA_W-1:0] M0_RDATA,
    output logic [1:0]        M0_RRESP,
    output logic              M0_RLAST,
    output logic              M0_RVALID,
    input  logic              M0_RREADY,
    // master 1
    input  logic [ID_W-1:0]   M1_ARID,
    input  logic [ADDR_W-1:0] M1_ARADDR,
    input  logic [LEN_W-1:0]  M1_ARLEN,
    input  logic              M1_ARVALID,
    output logic              M1_ARREADY,
    output logic [ID_W-1:0]   M1_RID,
    output logic [DATA_W-1:0] M1_RDATA,
    output logic [1:0]        M1_RRESP,
    output logic              M1_RLAST,
    output logic              M1_RVALID,
    input  logic              M1_RREADY,
    // slave
    output logic [ID_W-1:0]   S_ARID,
    output logic [ADDR_W-1:0] S_ARADDR,
    output logic [LEN_W-1:0]  S_ARLEN,
    output logic              S_ARVALID,
    input  logic              S_ARREADY,
    input  logic [ID_W-1:0]   S_RID,
    input  logic [DATA_W-1:0] S_RDATA,
    input  logic [1:0]        S_RRESP,
    input  logic              S_RLAST,
    input  logic              S_RVALID,
    output logic              S_RREADY
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    logic [1:0] r_state;
    logic       r_gnt;
    logic       r_last;

    logic       w_any_req;
    logic       w_win;
    logic       w_ar_hs;
    logic       w_r_done;

    assign w_any_req = M0_ARVALID | M1_ARVALID;
    assign w_ar_hs   = S_ARVALID & S_ARREADY;
    assign w_r_done  = S_RVALID & S_RREADY & S_RLAST;

    // Winner selection for the IDLE cycle; a lone requester always wins.
    always_comb begin
        w_win = 1'b0;
        if (M0_ARVALID && M1_ARVALID) begin
`ifdef ARB_RR_EN
            w_win = ~r_last;
`else
            // r_last is still tracked in this build but plays no part in the choice
            w_win = 1'b0 & r_last;
`endif
        end else if (M1_ARVALID) begin
            w_win = 1'b1;
        end else begin
            w_win = 1'b0;
        end
    end

    // Burst ownership FSM: grant is held from AR handshake until the RLAST beat is taken.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state <= ST_IDLE;
            r_gnt   <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_gnt   <= w_win;
                        r_state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (w_ar_hs) begin
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_r_done) begin
                        r_last  <= r_gnt;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Channel steering: only the owner sees the slave; everything else is held at zero.
    always_comb begin
        M0_ARREADY = 1'b0;
        M0_RID     = '0;
        M0_RDATA   = '0;
        M0_RRESP   = 2'b00;
        M0_RLAST   = 1'b0;
        M0_RVALID  = 1'b0;
        M1_ARREADY = 1'b0;
        M1_RID     = '0;
        M1_RDATA   = '0;
        M1_RRESP   = 2'b00;
        M1_RLAST   = 1'b0;
        M1_RVALID  = 1'b0;
        S_ARID     = '0;
        S_ARADDR   = '0;
        S_ARLEN    = '0;
        S_ARVALID  = 1'b0;
        S_RREADY   = 1'b0;
        case (r_state)
            ST_ADDR: begin
                if (r_gnt) begin
                    S_ARID     = M1_ARID;
                    S_ARADDR   = M1_ARADDR;
                    S_ARLEN    = M1_ARLEN;
                    S_ARVALID  = M1_ARVALID;
                    M1_ARREADY = S_ARREADY;
                end else begin
                    S_ARID     = M0_ARID;
                    S_ARADDR   = M0_ARADDR;
                    S_ARLEN    = M0_ARLEN;
                    S_ARVALID  = M0_ARVALID;
                    M0_ARREADY = S_ARREADY;
                end
            end
            ST_DATA: begin
                if (r_gnt) begin
                    M1_RID    = S_RID;
                    M1_RDATA  = S_RDATA;
                    M1_RRESP  = S_RRESP;
                    M1_RLAST  = S_RLAST;
                    M1_RVALID = S_RVALID;
                    S_RREADY  = M1_RREADY;
                end else begin
                    M0_RID    = S_RID;
                    M0_RDATA  = S_RDATA;
                    M0_RRESP  = S_RRESP;
                    M0_RLAST  = S_RLAST;
                    M0_RVALID = S_RVALID;
                    S_RREADY  = M0_RREADY;
                end
            end
            ST_IDLE: begin
                S_ARVALID = 1'b0;
            end
            default: begin
                S_ARVALID = 1'b0;
            end
        endcase
    end

endmodule
